// File: rtl/muxn_stream_arb.sv
// ---------------------------------------------------------------------------
// muxn_stream_arb
//   N-channel, W-bit packet-aware stream multiplexer with a single registered
//   output stage. The source channel is picked either by an external select
//   (MODE=0) or by a round-robin arbiter (MODE=1). Once the first beat of a
//   packet is accepted the grant stays on that channel until the beat
//   carrying LAST is accepted, so packets are never interleaved.
//
// Ports
//   CLK          rising-edge clock
//   ASYNCRESETN  asynchronous active-low reset (released synchronously
//                upstream)
//   I            input data, channel k at bits [k*W +: W]
//   I_LAST       end-of-packet flag per channel
//   I_VALID      valid per channel
//   I_READY      ready per channel (at most one bit high)
//   S            channel select, only used when MODE=0
//   O            registered output data
//   O_LAST       registered output end-of-packet
//   O_VALID      registered output valid
//   O_READY      downstream ready
//   GRANT        current / last granted channel
//   LOCKED       high while a multi-beat packet is in progress
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module muxn_stream_arb #(
  parameter  int N    = 2,
  parameter  int W    = 4,
  parameter  int MODE = 0,
  localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic            CLK,
  input  logic            ASYNCRESETN,
  input  logic [N*W-1:0]  I,
  input  logic [N-1:0]    I_LAST,
  input  logic [N-1:0]    I_VALID,
  output logic [N-1:0]    I_READY,
  input  logic [SW-1:0]   S,
  output logic [W-1:0]    O,
  output logic            O_LAST,
  output logic            O_VALID,
  input  logic            O_READY,
  output logic [SW-1:0]   GRANT,
  output logic            LOCKED
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Channel count in the same width as an extended select, so range checks
  // and modulo wrap stay free of width mismatches.
  localparam logic [SW:0] NVAL = (SW+1)'(N);

  state_t          r_state;
  logic [SW-1:0]   r_grant;
  logic [SW-1:0]   r_ptr;
  logic [W-1:0]    r_data;
  logic            r_last;
  logic            r_valid;

  logic            w_space;
  logic            w_locked;
  logic [SW-1:0]   w_cand;
  logic            w_candOk;
  logic [N-1:0]    w_ready;
  logic            w_accept;
  logic [W-1:0]    w_beatData;
  logic            w_beatLast;

  logic [2*N-1:0]  w_dblValid;
  logic [N-1:0]    w_rotValid;
  logic [SW-1:0]   w_rrOff;
  logic            w_rrHit;
  logic [SW:0]     w_rrSum;
  logic [SW:0]     w_rrWrap;
  logic [SW-1:0]   w_rrCand;

  // Modulo-N increment used for the round-robin pointer update.
  function automatic logic [SW-1:0] incMod(input logic [SW-1:0] x);
    if (x == SW'(N - 1)) begin
      return '0;
    end
    return x + SW'(1);
  endfunction

  assign w_locked = (r_state == ST_LOCKED);

  // The output register can take a beat if it is empty or being drained in
  // this very cycle, which gives one beat per cycle under full throughput.
  assign w_space = !r_valid || O_READY;

  // Rotate the valid vector so that bit 0 corresponds to the pointer; the
  // lowest set bit of the rotated vector is then the round-robin winner.
  assign w_dblValid = {I_VALID, I_VALID} >> r_ptr;
  assign w_rotValid = w_dblValid[N-1:0];

  always_comb begin
    w_rrOff = '0;
    w_rrHit = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rotValid[k]) begin
        w_rrOff = SW'(k);
        w_rrHit = 1'b1;
      end
    end
  end

  assign w_rrSum  = {1'b0, r_ptr} + {1'b0, w_rrOff};
  assign w_rrWrap = w_rrSum - NVAL;
  assign w_rrCand = (w_rrSum >= NVAL) ? w_rrWrap[SW-1:0] : w_rrSum[SW-1:0];

  // Candidate channel: the locked grant wins; otherwise the select input or
  // the round-robin winner. An out-of-range select yields no candidate.
  always_comb begin
    w_cand   = '0;
    w_candOk = 1'b0;
    if (w_locked) begin
      w_cand   = r_grant;
      w_candOk = 1'b1;
    end else if (MODE == 0) begin
      if ({1'b0, S} < NVAL) begin
        w_cand   = S;
        w_candOk = 1'b1;
      end
    end else begin
      w_cand   = w_rrCand;
      w_candOk = w_rrHit;
    end
  end

  // While locked the granted channel sees ready even without valid, so a
  // stalled producer keeps its slot and other channels cannot cut in.
  always_comb begin
    w_ready = '0;
    for (int k = 0; k < N; k++) begin
      w_ready[k] = w_candOk && (w_cand == SW'(k)) && w_space &&
                   (w_locked || I_VALID[k]);
    end
  end

  assign w_accept = |(w_ready & I_VALID);

  always_comb begin
    w_beatData = '0;
    w_beatLast = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (w_cand == SW'(k)) begin
        w_beatData = I[k*W +: W];
        w_beatLast = I_LAST[k];
      end
    end
  end

  // Output stage and packet FSM. The pointer only advances at packet end so
  // fairness is per packet rather than per beat.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data  <= w_beatData;
        r_last  <= w_beatLast;
        r_valid <= 1'b1;
      end else if (O_READY) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_grant <= w_cand;
            if (w_beatLast) begin
              r_ptr <= incMod(w_cand);
            end else begin
              r_state <= ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (w_accept && w_beatLast) begin
            r_state <= ST_IDLE;
            r_ptr   <= incMod(r_grant);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign I_READY = w_ready;
  assign O       = r_data;
  assign O_LAST  = r_last;
  assign O_VALID = r_valid;
  assign GRANT   = r_grant;
  assign LOCKED  = w_locked;

endmodule
